// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic WIDTH-bit pipeline stage placed between two pipeline stages. It
// carries the packed control/data bundle of the upstream stage, supports a
// synchronous flush to a configurable bubble value, and optionally adds a
// second (skid) entry so that upstream READY_O is driven straight from a flop.
//
// Handshake: a beat moves upstream->stage on a rising CLK edge where
// VALID_I & READY_O, and stage->downstream where VALID_O & READY_I. VALID_O
// and DATA_O never depend on READY_I within a cycle; DATA_O equals BUBBLE
// whenever VALID_O is low.
//
// Parameters:
//   WIDTH  payload width
//   BUBBLE payload presented while VALID_O=0 (safe NOP encoding)
//   SKID   0: single entry, READY_O = ~VALID_O | READY_I (combinational)
//          1: main + skid entry, READY_O registered
//   CNT_W  stall counter width
//
// Ports:
//   CLK        clock, rising edge
//   RSTN       asynchronous active-low reset
//   FLUSH      synchronous flush of held entries and the beat offered now
//   VALID_I    upstream beat valid
//   READY_O    stage can accept a beat this cycle
//   DATA_I     upstream payload
//   VALID_O    downstream beat valid
//   READY_I    downstream accepts the beat this cycle
//   DATA_O     downstream payload (registered)
//   STALL_CNT  saturating count of cycles with VALID_O & ~READY_I
//   STATE_O    occupancy state for debug (0 empty, 1 one entry, 2 two)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int               SKID   = 1,
    parameter int               CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             FLUSH,
    input  logic             VALID_I,
    output logic             READY_O,
    input  logic [WIDTH-1:0] DATA_I,
    output logic             VALID_O,
    input  logic             READY_I,
    output logic [WIDTH-1:0] DATA_O,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [1:0]       STATE_O
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic out_valid;
    logic push;
    logic pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign pop       = out_valid & READY_I;

    // With the skid entry present, READY_O comes from a flop only, which
    // breaks the combinational ready chain between pipeline stages.
    assign READY_O   = (SKID != 0) ? ready_q : (~out_valid | READY_I);
    assign push      = VALID_I & READY_O;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (FLUSH) begin
            // A beat popped this cycle is already owned downstream; a beat
            // pushed this cycle is dropped along with everything held.
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else if (SKID != 0) begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = DATA_I;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = DATA_I;
                    end else if (push) begin
                        state_d = ST_TWO;
                        skid_d  = DATA_I;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_TWO: begin
                    // READY_O is low here, so only a pop can happen.
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end else begin
            if (push) begin
                state_d = ST_ONE;
                main_d  = DATA_I;
            end else if (pop) begin
                state_d = ST_EMPTY;
                main_d  = BUBBLE;
            end
        end
    end

    // Ready for next cycle is known from the next occupancy alone.
    assign ready_d = (state_d != ST_TWO);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    // Saturating back-pressure counter; survives FLUSH on purpose so that
    // performance counts span pipeline redirects.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !READY_I && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign VALID_O   = out_valid;
    assign DATA_O    = main_q;
    assign STALL_CNT = stall_cnt_q;
    assign STATE_O   = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Two stages share one stimulus stream: index 0 is SKID=1 with a 16-bit stall
// counter, index 1 is SKID=0 with a 4-bit stall counter. Each stage has its
// own expected queue; beats accepted upstream are pushed, beats delivered
// downstream are popped and compared. Valid, ready and stall count are
// predicted from the queue occupancy and the stage mode.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int         W   = 32;
    localparam logic [W-1:0] BUB = 32'hBBBB_0000;

    // ---------------- clock / reset ----------------
    logic         clk     = 1'b0;
    logic         rstn    = 1'b0;
    logic         flush   = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [W-1:0] data_i  = '0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic         a_ready_o, a_valid_o;
    logic [W-1:0] a_data_o;
    logic [15:0]  a_stall;
    logic [1:0]   a_state;

    logic         b_ready_o, b_valid_o;
    logic [W-1:0] b_data_o;
    logic [3:0]   b_stall;
    logic [1:0]   b_state;

    pipe_stage_skid #(.WIDTH(W), .BUBBLE(BUB), .SKID(1), .CNT_W(16)) u_skid1 (
        .CLK(clk), .RSTN(rstn), .FLUSH(flush),
        .VALID_I(valid_i), .READY_O(a_ready_o), .DATA_I(data_i),
        .VALID_O(a_valid_o), .READY_I(ready_i), .DATA_O(a_data_o),
        .STALL_CNT(a_stall), .STATE_O(a_state)
    );

    pipe_stage_skid #(.WIDTH(W), .BUBBLE(BUB), .SKID(0), .CNT_W(4)) u_skid0 (
        .CLK(clk), .RSTN(rstn), .FLUSH(flush),
        .VALID_I(valid_i), .READY_O(b_ready_o), .DATA_I(data_i),
        .VALID_O(b_valid_o), .READY_I(ready_i), .DATA_O(b_data_o),
        .STALL_CNT(b_stall), .STATE_O(b_state)
    );

    logic         vo[2];
    logic         ro[2];
    logic [W-1:0] dout[2];
    logic [15:0]  cnt_o[2];

    assign vo[0]    = a_valid_o;
    assign vo[1]    = b_valid_o;
    assign ro[0]    = a_ready_o;
    assign ro[1]    = b_ready_o;
    assign dout[0]  = a_data_o;
    assign dout[1]  = b_data_o;
    assign cnt_o[0] = a_stall;
    assign cnt_o[1] = {12'b0, b_stall};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[2][$];
    logic [15:0]  cnt_m[2];
    logic [15:0]  cnt_max[2];
    string        nm[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            cnt_m[d] = '0;
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called at the falling edge with inputs already driven; compares the
    // current outputs, updates the model with this cycle's handshakes, and
    // returns at the next falling edge.
    task automatic tick();
        logic         exp_v;
        logic         exp_r;
        logic [W-1:0] exp_d;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_v = (exp_q[d].size() != 0);
            exp_r = (d == 0) ? (exp_q[d].size() < 2) : (!exp_v || ready_i);
            check({nm[d], ".valid"}, vo[d], exp_v);
            check({nm[d], ".ready"}, ro[d], exp_r);
            check({nm[d], ".stall"}, cnt_o[d], cnt_m[d]);
            if (!exp_v) begin
                check({nm[d], ".bubble"}, dout[d], BUB);
            end else if (ready_i) begin
                exp_d = exp_q[d].pop_front();
                check({nm[d], ".data"}, dout[d], exp_d);
            end
            if (exp_v && !ready_i && cnt_m[d] != cnt_max[d]) cnt_m[d]++;
            if (flush) exp_q[d].delete();
            else if (valid_i && exp_r) exp_q[d].push_back(data_i);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush   = f;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nm[0] = "skid1";
        nm[1] = "skid0";
        cnt_max[0] = 16'hFFFF;
        cnt_max[1] = 16'h000F;
        model_reset();

        // Reset held with a beat offered upstream.
        rstn    = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hDEAD_BEEF;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.a_valid", a_valid_o, 1'b0);
        check("rst.a_data",  a_data_o,  BUB);
        check("rst.a_ready", a_ready_o, 1'b1);
        check("rst.a_stall", a_stall,   16'h0);
        check("rst.b_valid", b_valid_o, 1'b0);
        check("rst.b_data",  b_data_o,  BUB);
        check("rst.b_ready", b_ready_o, 1'b1);
        check("rst.b_stall", b_stall,   4'h0);
        check("rst.a_state", a_state,   2'd0);

        // First push after release.
        rstn = 1'b1;
        drive(1'b1, 32'h1, 1'b0, 1'b0);
        check("first.a_valid", a_valid_o, 1'b1);
        check("first.a_data",  a_data_o,  32'h1);
        check("first.b_data",  b_data_o,  32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming 0..99 at full rate.
        for (int i = 0; i < 100; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: 1,2,3 with downstream stalled from the second beat.
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        drive(1'b1, 32'h2, 1'b0, 1'b0);
        check("bp.a_state", a_state, 2'd2);
        check("bp.a_ready", a_ready_o, 1'b0);
        repeat (3) drive(1'b1, 32'h3, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 32'h3, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush in TWO with a concurrent push.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        check("fl.a_state", a_state, 2'd2);
        drive(1'b1, 32'h12, 1'b0, 1'b1);
        check("fl.a_valid", a_valid_o, 1'b0);
        check("fl.a_data",  a_data_o,  BUB);
        check("fl.a_ready", a_ready_o, 1'b1);
        check("fl.b_valid", b_valid_o, 1'b0);
        drive(1'b1, 32'h20, 1'b1, 1'b0);
        drive(1'b1, 32'h21, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while the held beat is being popped: that beat is delivered.
        drive(1'b1, 32'h30, 1'b1, 1'b0);
        drive(1'b1, 32'h31, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Counter saturation on the 4-bit stage, then flush keeps it.
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        repeat (20) drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("sat.b_stall", b_stall, 4'hF);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("sat.b_flush", b_stall, 4'hF);

        // Asynchronous reset in the middle of a transfer.
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b1, 32'h41, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("arst.a_valid", a_valid_o, 1'b0);
        check("arst.a_ready", a_ready_o, 1'b1);
        check("arst.a_data",  a_data_o,  BUB);
        check("arst.a_stall", a_stall,   16'h0);
        check("arst.b_stall", b_stall,   4'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 32'h42, 1'b1, 1'b0);
        check("arst.first", a_data_o, 32'h42);

        // Randomised traffic.
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end
        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised successor to the fixed-field inter-stage pipeline registers: one generic WIDTH-bit pipeline stage with valid/ready handshake, synchronous flush to a configurable bubble value, and an optional 2-entry skid buffer that makes upstream ready a pure flop output. It sits between any two pipeline stages (F/D, D/E, E/M, M/W) and carries the packed control and data bundle of the upstream stage. A saturating stall counter exposes back-pressure cycles for performance debug.

## Interface
- WIDTH, 32: payload width in bits.
- BUBBLE, {WIDTH{1'b0}}: payload value driven on DATA_O whenever VALID_O=0 (safe NOP encoding, e.g. WEN/DREQ inactive bits preset).
- SKID, 1: 0 = single register with combinational ready; 1 = main + skid register, registered ready.
- CNT_W, 16: stall counter width.
- CLK  in  1  clock, all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous flush; kills all held entries and the beat offered this cycle.
- VALID_I  in  1  upstream beat valid.
- READY_O  out  1  stage can accept a beat this cycle.
- DATA_I  in  WIDTH  upstream payload.
- VALID_O  out  1  downstream beat valid.
- READY_I  in  1  downstream accepts the beat this cycle.
- DATA_O  out  WIDTH  downstream payload; equals BUBBLE when VALID_O=0.
- STALL_CNT  out  CNT_W  saturating count of cycles with VALID_O=1 and READY_I=0.

## Operation
- Beat transfers upstream when VALID_I & READY_O; downstream when VALID_O & READY_I.
- SKID=0: one entry. READY_O = ~VALID_O | READY_I (combinational). On push the entry loads DATA_I; on pop without push VALID_O<=0, DATA_O<=BUBBLE; no push and no pop holds.
- SKID=1: states EMPTY (no entry), ONE (main valid), TWO (main + skid valid). READY_O = ~skid_valid, flop-driven only.
  - EMPTY: push -> ONE (main<=DATA_I).
  - ONE: push & pop -> ONE (main<=DATA_I); push & ~pop -> TWO (skid<=DATA_I); pop & ~push -> EMPTY; else hold.
  - TWO: READY_O=0, no push possible; pop -> ONE (main<=skid, skid cleared to BUBBLE); else hold.
- Ordering strictly FIFO; no beat duplicated or lost except by FLUSH.
- FLUSH (highest priority after reset): next state EMPTY/invalid, VALID_O<=0, DATA_O<=BUBBLE, skid cleared; a beat handshaken upstream in the flush cycle is discarded; a beat popped downstream in the flush cycle still counts as delivered (downstream owns it).
- STALL_CNT: +1 each cycle VALID_O & ~READY_I, holds at all-ones, not cleared by FLUSH; cleared only by reset.
- Reset values: VALID_O=0, DATA_O=BUBBLE, READY_O=1, STALL_CNT=0, skid invalid.

## Timing
- Latency: beat pushed at edge N is visible on VALID_O/DATA_O after edge N (one cycle), both modes.
- Throughput: one beat per cycle sustained when READY_I=1, both modes.
- SKID=1: READY_O falls the cycle after downstream stalls with main full and a push occurs; up to one extra beat absorbed; READY_O rises the cycle after the skid drains.
- SKID=0: READY_O has a combinational path from READY_I; SKID=1 has none.
- FLUSH effective at the next edge; VALID_O=0 in the cycle after FLUSH regardless of VALID_I/READY_I.
- RSTN assertion mid-transfer clears immediately (asynchronous); first push accepted on the first edge after release.
- DATA_O is registered in both modes (no mux from DATA_I to DATA_O).

## Test plan
- Reset: hold RSTN=0 with VALID_I=1, DATA_I=32'hDEAD_BEEF -> VALID_O=0, DATA_O=BUBBLE, READY_O=1, STALL_CNT=0; release, push 32'h1 -> VALID_O=1, DATA_O=32'h1 next cycle.
- Streaming: push 0..99 back-to-back with READY_I=1 -> outputs 0..99 in order, one per cycle, latency 1, STALL_CNT=0.
- Back-pressure (SKID=1): stream 1,2,3 with READY_I=0 from cycle 2 -> main=1, skid=2, READY_O=0, 3 held upstream; READY_I=1 -> outputs 1,2,3 in order, STALL_CNT equals stall cycles.
- Flush in TWO state plus concurrent push -> next cycle VALID_O=0, DATA_O=BUBBLE, READY_O=1, none of the held or offered beats ever appear.
- Randomised VALID_I/READY_I, 10k cycles, both SKID values -> scoreboard exact order match, DATA_O==BUBBLE whenever VALID_O=0.
- Counter saturation with CNT_W=4: hold VALID_O=1, READY_I=0 for 20 cycles -> STALL_CNT stops at 4'hF; FLUSH leaves it 4'hF.
